lc4_div_arbiter: RTL and testbench
==================================

LC4_DIV_ARBITER -- requirements
Module: lc4_div_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: gwe  input  1  global write enable; when 0, all state holds.
REQ-004 SHALL have port: i_flush  input  1  aborts any in-flight operation.
REQ-005 SHALL have ports: i_req_a, i_req_b  input  1 each  request from pipe A (older slot) and pipe B.
REQ-006 SHALL have ports: i_dividend_a, i_divisor_a, i_dividend_b, i_divisor_b  input  16 each  unsigned operands.
REQ-007 SHALL have ports: i_mod_a, i_mod_b  input  1 each  0 selects DIV (quotient), 1 selects MOD (remainder).
REQ-008 SHALL have ports: o_ack_a, o_ack_b  output  1 each  accept pulse in the cycle a request is captured.
REQ-009 SHALL have port: o_done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have port: o_done_id  output  1  owner of the result (0 = A, 1 = B).
REQ-011 SHALL have port: o_result  output  16  quotient or remainder, selected by the captured op.
REQ-012 SHALL have port: o_busy  output  1  asserted in CALC and DONE.

Function
REQ-013 SHALL implement a single shared unsigned iterative divider with FSM states IDLE, CALC and DONE.
REQ-014 SHALL accept a request only in IDLE with gwe=1 and i_flush=0, capturing operands, op and owner id.
REQ-015 SHALL use fixed priority when both requesters are active: A wins, B is not acked and must hold its request.
REQ-016 SHALL assert o_ack_a and o_ack_b combinationally in the accept cycle only, and never both together.
REQ-017 SHALL, when the accepted divisor is nonzero, go IDLE->CALC and perform exactly 16 restoring iterations, one quotient bit per gwe-enabled cycle, MSB first.
REQ-018 SHALL go CALC->DONE after the 16th iteration, and DONE->IDLE after one gwe-enabled cycle.
REQ-019 SHALL, when the accepted divisor is 0, go IDLE->DONE directly with quotient=0 and remainder=0.
REQ-020 SHALL assert o_done only in DONE; o_result and o_done_id SHALL be stable while o_done=1.
REQ-021 SHALL give latency (gwe=1 throughout): accept at cycle T, o_done at T+17 for a nonzero divisor, T+1 for a zero divisor.
REQ-022 SHALL set the earliest next accept to T+18 (nonzero) or T+2 (zero); no accept occurs in CALC or DONE.
REQ-023 SHALL keep the iteration counter 5 bits wide, counting 0..15 with no wrap-around.
REQ-024 SHALL, with gwe=0, hold the state, counter and datapath registers, and assert no acks; o_done remains a function of the held state.
REQ-025 SHALL, on i_flush=1 with gwe=1 in any state, go to IDLE next cycle, discard the operation, suppress acks that cycle and produce no o_done.
REQ-026 SHALL give rst priority over i_flush, and i_flush priority over requests.
REQ-027 SHALL keep results bit-exact to the LC4 DIV/MOD definition, including the divisor=0 case.

Reset
REQ-028 SHALL, on rst=1 at a clock edge (regardless of gwe), set: state=IDLE, counter=0, datapath registers=0, o_done=0, o_done_id=0, o_result=0x0000, o_busy=0, o_ack_a=0, o_ack_b=0.
REQ-029 SHALL, on reset mid-operation, abandon the operation silently with no o_done.

Structure
REQ-030 SHALL place the state encodings, op encodings (DIV=0, MOD=1), ITER=16 and the owner-id encoding in the shared header lc4_div_defs.
REQ-031 SHALL factor one restoring iteration (remainder, quotient and divisor in; next remainder and quotient out) into sub-module lc4_div_step, instantiated once.
REQ-032 SHALL contain no combinational path from the operand inputs to o_result.

Verification
REQ-033 SHALL cover: A requests 100/7 with DIV -> ack_a at T, o_done at T+17, result 0x000E, id 0.
REQ-034 SHALL cover: A and B request together (A 100 MOD 7; B 0xFFFF DIV 0x0010) -> A result 0x0002 at T+17; B acked at T+18, result 0x0FFF at T+35, id 1.
REQ-035 SHALL cover: B requests 0x1234 DIV 0 -> o_done at T+1, result 0x0000; a new accept is possible at T+2.
REQ-036 SHALL cover: A accepts 50/5, then i_flush at T+8 -> IDLE at T+9, no o_done; a new request is acked at T+9.
REQ-037 SHALL cover: gwe held low for 3 cycles mid-CALC -> o_done delayed to T+20, result still correct; separately, rst at T+5 -> all outputs 0 and no o_done.

Source files
------------

// File: rtl/lc4_div_defs.sv
// ---------------------------------------------------------------------------
// lc4_div_defs
// Shared definitions for the LC4 DIV/MOD arbiter:
//   state_e  - divider FSM states (IDLE, CALC, DONE)
//   op_e     - operation select (DIV = quotient, MOD = remainder)
//   id_e     - result owner (A = older pipe slot, B)
//   ITER     - number of restoring iterations (one per quotient bit)
// ---------------------------------------------------------------------------
package lc4_div_defs;

    localparam int W    = 16;
    localparam int ITER = 16;
    localparam int CW   = 5;

    // Counter value of the final iteration; the counter never passes it.
    localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_DIV = 1'b0,
        OP_MOD = 1'b1
    } op_e;

    typedef enum logic {
        ID_A = 1'b0,
        ID_B = 1'b1
    } id_e;

endpackage

// File: rtl/lc4_div_arbiter_if.sv
// ---------------------------------------------------------------------------
// lc4_div_arbiter_if
// Request/result bundle between the two issuing pipes and the shared divider.
//   i_req_a/b, i_dividend_a/b, i_divisor_a/b, i_mod_a/b : requester -> divider
//   o_ack_a/b                                          : accept pulses
//   o_done, o_done_id, o_result                        : result pulse, owner, value
//   o_busy                                             : divider occupied
// master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface lc4_div_arbiter_if;
    import lc4_div_defs::*;

    logic         i_req_a;
    logic         i_req_b;
    logic [W-1:0] i_dividend_a;
    logic [W-1:0] i_divisor_a;
    logic [W-1:0] i_dividend_b;
    logic [W-1:0] i_divisor_b;
    logic         i_mod_a;
    logic         i_mod_b;
    logic         o_ack_a;
    logic         o_ack_b;
    logic         o_done;
    logic         o_done_id;
    logic [W-1:0] o_result;
    logic         o_busy;

    modport master (
        output i_req_a, i_req_b, i_dividend_a, i_divisor_a,
               i_dividend_b, i_divisor_b, i_mod_a, i_mod_b,
        input  o_ack_a, o_ack_b, o_done, o_done_id, o_result, o_busy
    );

    modport slave (
        input  i_req_a, i_req_b, i_dividend_a, i_divisor_a,
               i_dividend_b, i_divisor_b, i_mod_a, i_mod_b,
        output o_ack_a, o_ack_b, o_done, o_done_id, o_result, o_busy
    );

endinterface

// File: rtl/lc4_div_step.sv
// ---------------------------------------------------------------------------
// lc4_div_step
// One restoring-division iteration, purely combinational.
//   i_rem : partial remainder so far
//   i_quo : shift register; upper bits hold remaining dividend bits, lower
//           bits collect quotient bits (MSB first)
//   i_div : divisor
//   o_rem : next partial remainder
//   o_quo : i_quo shifted left with the new quotient bit in bit 0
// ---------------------------------------------------------------------------
module lc4_div_step
    import lc4_div_defs::*;
(
    input  logic [W-1:0] i_rem,
    input  logic [W-1:0] i_quo,
    input  logic [W-1:0] i_div,
    output logic [W-1:0] o_rem,
    output logic [W-1:0] o_quo
);

    logic [W:0] trial;
    logic [W:0] diff;
    logic       fits;

    always_comb begin
        // The shifted remainder can need W+1 bits before the subtract.
        trial = {i_rem, i_quo[W-1]};
        diff  = trial - {1'b0, i_div};
        // No borrow out of the top bit means trial >= divisor.
        fits  = ~diff[W];
        o_rem = fits ? diff[W-1:0] : trial[W-1:0];
        o_quo = {i_quo[W-2:0], fits};
    end

endmodule

// File: rtl/lc4_div_arbiter.sv
// ---------------------------------------------------------------------------
// lc4_div_arbiter
// Shared unsigned iterative divider arbitrated between pipe A (priority) and
// pipe B. Accepts one request in IDLE, runs 16 restoring iterations in CALC,
// then presents the quotient or remainder for one cycle in DONE.
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (overrides gwe and i_flush)
//   gwe     : global write enable; all state holds while low
//   i_flush : abandons any in-flight operation (overrides requests)
//   bus     : request/result bundle (slave side)
// o_result is driven only from registers, never from the operand inputs.
// ---------------------------------------------------------------------------
module lc4_div_arbiter
    import lc4_div_defs::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               gwe,
    input  logic               i_flush,
    lc4_div_arbiter_if.slave   bus
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  rem_q,   rem_d;
    logic [W-1:0]  quo_q,   quo_d;
    logic [W-1:0]  dvs_q,   dvs_d;
    op_e           op_q,    op_d;
    id_e           id_q,    id_d;

    logic          ack_a;
    logic          ack_b;
    logic          take_b;
    logic [W-1:0]  sel_dividend;
    logic [W-1:0]  sel_divisor;
    logic [W-1:0]  step_rem;
    logic [W-1:0]  step_quo;

    lc4_div_step u_step (
        .i_rem (rem_q),
        .i_quo (quo_q),
        .i_div (dvs_q),
        .o_rem (step_rem),
        .o_quo (step_quo)
    );

    // A wins whenever it requests; B is taken only when A is idle.
    always_comb begin
        take_b       = ~bus.i_req_a;
        sel_dividend = take_b ? bus.i_dividend_b : bus.i_dividend_a;
        sel_divisor  = take_b ? bus.i_divisor_b  : bus.i_divisor_a;
    end

    // NOTE: every signal gets its default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        op_d    = op_q;
        id_d    = id_q;
        ack_a   = 1'b0;
        ack_b   = 1'b0;

        if (gwe && !rst) begin
            if (i_flush) begin
                state_d = ST_IDLE;
                count_d = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.i_req_a || bus.i_req_b) begin
                            ack_a   = ~take_b;
                            ack_b   = take_b;
                            id_d    = take_b ? ID_B : ID_A;
                            op_d    = op_e'(take_b ? bus.i_mod_b : bus.i_mod_a);
                            dvs_d   = sel_divisor;
                            rem_d   = '0;
                            count_d = '0;
                            if (sel_divisor == '0) begin
                                // LC4 defines both results as 0 for a zero divisor.
                                quo_d   = '0;
                                state_d = ST_DONE;
                            end else begin
                                quo_d   = sel_dividend;
                                state_d = ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        rem_d = step_rem;
                        quo_d = step_quo;
                        if (count_q == CNT_LAST) begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    ST_DONE: state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    // NOTE: datapath registers are reset too, so o_result reads 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            op_q    <= OP_DIV;
            id_q    <= ID_A;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            op_q    <= op_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        bus.o_ack_a   = ack_a;
        bus.o_ack_b   = ack_b;
        bus.o_done    = (state_q == ST_DONE);
        bus.o_busy    = (state_q != ST_IDLE);
        bus.o_done_id = id_q;
        bus.o_result  = '0;
        if (state_q == ST_DONE) begin
            bus.o_result = (op_q == OP_MOD) ? rem_q : quo_q;
        end
    end

endmodule

// File: tb/tb_lc4_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc4_div_arbiter
// Directed bench for lc4_div_arbiter. Expected results are pushed to a
// scoreboard at accept time and popped when o_done is observed.
// ---------------------------------------------------------------------------
module tb_lc4_div_arbiter;

    typedef struct {
        logic        id;
        logic [15:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic gwe;
    logic i_flush;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   t0;
    exp_t sb[$];

    lc4_div_arbiter_if bus ();

    lc4_div_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .gwe     (gwe),
        .i_flush (i_flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic id, input logic [15:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    // Waits (bounded) for o_done, compares against the scoreboard head and
    // the expected latency, then steps one cycle to confirm a single pulse.
    task automatic expect_done(input string tag, input int start, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (bus.o_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, 32'(bus.o_done), 32'd1);
        if (bus.o_done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(bus.o_result), 32'(e.res));
            check({tag, "_id"}, 32'(bus.o_done_id), 32'(e.id));
            check({tag, "_latency"}, 32'(cyc - start), 32'(lat));
            check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
            check({tag, "_no_ack_done"}, 32'({bus.o_ack_a, bus.o_ack_b}), 32'd0);
            tick();
            check({tag, "_pulse"}, 32'(bus.o_done), 32'd0);
        end
    endtask

    task automatic clear_reqs();
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
    endtask

    initial begin
        int done_cnt;

        rst = 1'b1;
        gwe = 1'b0;
        i_flush = 1'b0;
        bus.i_req_a = 1'b0;
        bus.i_req_b = 1'b0;
        bus.i_dividend_a = '0;
        bus.i_divisor_a = '0;
        bus.i_dividend_b = '0;
        bus.i_divisor_b = '0;
        bus.i_mod_a = 1'b0;
        bus.i_mod_b = 1'b0;

        // Reset with gwe low must still clear everything.
        tick();
        tick();
        check("rst_done", 32'(bus.o_done), 32'd0);
        check("rst_busy", 32'(bus.o_busy), 32'd0);
        check("rst_result", 32'(bus.o_result), 32'd0);
        check("rst_id", 32'(bus.o_done_id), 32'd0);
        check("rst_acks", 32'({bus.o_ack_a, bus.o_ack_b}), 32'd0);
        rst = 1'b0;
        gwe = 1'b1;
        tick();

        // 100 / 7 from A.
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd100;
        bus.i_divisor_a = 16'd7;
        bus.i_mod_a = 1'b0;
        #1;
        check("div_ack_a", 32'({bus.o_ack_a, bus.o_ack_b}), 32'b10);
        push(1'b0, 16'h000E);
        t0 = cyc;
        tick();
        clear_reqs();
        expect_done("div", t0, 17);

        // A and B together: A wins, B holds and is taken right after DONE.
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd100;
        bus.i_divisor_a = 16'd7;
        bus.i_mod_a = 1'b1;
        bus.i_req_b = 1'b1;
        bus.i_dividend_b = 16'hFFFF;
        bus.i_divisor_b = 16'h0010;
        bus.i_mod_b = 1'b0;
        #1;
        check("both_ack", 32'({bus.o_ack_a, bus.o_ack_b}), 32'b10);
        push(1'b0, 16'h0002);
        t0 = cyc;
        tick();
        bus.i_req_a = 1'b0;
        #1;
        check("calc_no_ack_b", 32'(bus.o_ack_b), 32'd0);
        expect_done("mod_a", t0, 17);
        check("b_ack", 32'({bus.o_ack_a, bus.o_ack_b}), 32'b01);
        check("b_ack_time", 32'(cyc - t0), 32'd18);
        push(1'b1, 16'h0FFF);
        tick();
        clear_reqs();
        expect_done("div_b", t0, 35);

        // Zero divisor from B: done next cycle, new accept one cycle later.
        bus.i_req_b = 1'b1;
        bus.i_dividend_b = 16'h1234;
        bus.i_divisor_b = 16'h0000;
        bus.i_mod_b = 1'b0;
        #1;
        check("zero_ack_b", 32'({bus.o_ack_a, bus.o_ack_b}), 32'b01);
        push(1'b1, 16'h0000);
        t0 = cyc;
        tick();
        clear_reqs();
        expect_done("zero", t0, 1);
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd9;
        bus.i_divisor_a = 16'd3;
        bus.i_mod_a = 1'b0;
        #1;
        check("zero_next_ack", 32'(bus.o_ack_a), 32'd1);
        check("zero_next_time", 32'(cyc - t0), 32'd2);
        push(1'b0, 16'd3);
        t0 = cyc;
        tick();
        clear_reqs();
        expect_done("after_zero", t0, 17);

        // Flush mid-CALC: flushed op never completes, new request taken at T+9.
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd50;
        bus.i_divisor_a = 16'd5;
        bus.i_mod_a = 1'b0;
        #1;
        check("flush_acc", 32'(bus.o_ack_a), 32'd1);
        t0 = cyc;
        tick();
        clear_reqs();
        advance_to(t0 + 8);
        i_flush = 1'b1;
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd21;
        bus.i_divisor_a = 16'd4;
        bus.i_mod_a = 1'b1;
        #1;
        check("flush_no_ack", 32'(bus.o_ack_a), 32'd0);
        tick();
        i_flush = 1'b0;
        #1;
        check("flush_idle", 32'(bus.o_busy), 32'd0);
        check("flush_new_ack", 32'(bus.o_ack_a), 32'd1);
        push(1'b0, 16'd1);
        t0 = cyc;
        tick();
        clear_reqs();
        expect_done("post_flush", t0, 17);

        // gwe low for three cycles mid-CALC stretches latency to 20.
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd200;
        bus.i_divisor_a = 16'd9;
        bus.i_mod_a = 1'b0;
        #1;
        check("gwe_acc", 32'(bus.o_ack_a), 32'd1);
        push(1'b0, 16'h0016);
        t0 = cyc;
        tick();
        clear_reqs();
        advance_to(t0 + 5);
        gwe = 1'b0;
        advance_to(t0 + 8);
        gwe = 1'b1;
        expect_done("gwe_stall", t0, 20);

        // gwe low in IDLE: request is neither acked nor captured.
        gwe = 1'b0;
        bus.i_req_a = 1'b1;
        bus.i_dividend_a = 16'd7;
        bus.i_divisor_a = 16'd1;
        #1;
        check("gwe_idle_no_ack", 32'(bus.o_ack_a), 32'd0);
        tick();
        check("gwe_idle_hold", 32'(bus.o_busy), 32'd0);
        clear_reqs();
        gwe = 1'b1;
        tick();

        // Reset mid-CALC: operation abandoned, no o_done ever appears.
        bus.i_req_b = 1'b1;
        bus.i_dividend_b = 16'd1000;
        bus.i_divisor_b = 16'd3;
        bus.i_mod_b = 1'b0;
        #1;
        check("rst_op_ack", 32'(bus.o_ack_b), 32'd1);
        t0 = cyc;
        tick();
        clear_reqs();
        advance_to(t0 + 5);
        rst = 1'b1;
        bus.i_req_a = 1'b1;
        #1;
        check("rst_no_ack", 32'({bus.o_ack_a, bus.o_ack_b}), 32'd0);
        tick();
        rst = 1'b0;
        clear_reqs();
        #1;
        check("mid_rst_busy", 32'(bus.o_busy), 32'd0);
        check("mid_rst_done", 32'(bus.o_done), 32'd0);
        check("mid_rst_result", 32'(bus.o_result), 32'd0);
        check("mid_rst_id", 32'(bus.o_done_id), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.o_done === 1'b1) done_cnt++;
        end
        check("mid_rst_no_done", 32'(done_cnt), 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
